// File: rtl/swim_rx_decoder.sv
// swim_rx_decoder
//
// Receive side of the single-wire SWIM link. Each low pulse on the line is
// measured in clk cycles and classified as bit 1 (short low) or bit 0 (long
// low). Target-to-host frames are assembled from a start bit (1), DATA_BITS
// data bits sent MSB first, and an even parity bit. One byte is delivered per
// frame, with a single-cycle strobe.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   swim_in   asynchronous SWIM line level, idle high
//   data      payload of the last completed frame (also updated on parity error)
//   valid     one-cycle strobe: frame received with good parity
//   err       one-cycle strobe: frame aborted or bad
//   err_code  01 start bit was 0, 10 parity mismatch, 11 timeout; held until next err
//   busy      high while a frame is in progress

module swim_rx_decoder #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned MIN_LOW_CLKS = 4,
   parameter int unsigned THRESH_CLKS  = 66,
   parameter int unsigned TIMEOUT_CLKS = 2048
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 swim_in,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic                 busy
);

   localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
   localparam int unsigned TmrW = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity
   } state_e;

   state_e               state_q;
   logic [1:0]           sync_q;     // [0] first stage, [1] synchronized line
   logic                 line_q;     // previous synchronized level, for edges
   logic [15:0]          low_cnt_q;
   logic [IdxW-1:0]      bit_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [TmrW-1:0]      timer_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 err_q;
   logic [1:0]           err_code_q;

   logic fall;
   logic rise;
   logic bit_ok;
   logic bit_val;
   logic timeout;

   always_comb begin
      fall    = line_q & ~sync_q[1];
      rise    = ~line_q & sync_q[1];
      // Pulses shorter than MIN_LOW_CLKS are glitches and leave everything alone.
      bit_ok  = rise && (low_cnt_q >= 16'(MIN_LOW_CLKS));
      bit_val = (low_cnt_q < 16'(THRESH_CLKS));
      timeout = (state_q != StIdle) && (timer_q == TmrW'(TIMEOUT_CLKS - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= 2'b11;
         line_q     <= 1'b1;
         low_cnt_q  <= '0;
         state_q    <= StIdle;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         timer_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], swim_in};
         line_q <= sync_q[1];

         // The falling-edge cycle is itself a low cycle, so the count restarts
         // at 1; at the rising edge the count equals the pulse width.
         if (fall) begin
            low_cnt_q <= 16'd1;
         end else if (!sync_q[1] && (low_cnt_q != 16'hFFFF)) begin
            low_cnt_q <= low_cnt_q + 16'd1;
         end

         valid_q <= 1'b0;
         err_q   <= 1'b0;

         // A bit decoded on the timeout cycle takes priority over the timeout.
         if (bit_ok) begin
            timer_q <= '0;
            unique case (state_q)
               StIdle: begin
                  if (bit_val) begin
                     state_q   <= StData;
                     bit_idx_q <= '0;
                     shift_q   <= '0;
                  end else begin
                     err_q      <= 1'b1;
                     err_code_q <= 2'b01;
                  end
               end
               StData: begin
                  shift_q <= {shift_q[DATA_BITS-2:0], bit_val};
                  if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
                     state_q <= StParity;
                  end else begin
                     bit_idx_q <= bit_idx_q + IdxW'(1);
                  end
               end
               StParity: begin
                  data_q  <= shift_q;
                  state_q <= StIdle;
                  if (bit_val == (^shift_q)) begin
                     valid_q <= 1'b1;
                  end else begin
                     err_q      <= 1'b1;
                     err_code_q <= 2'b10;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end else if (timeout) begin
            // Partial frame is dropped; data keeps the last delivered payload.
            state_q    <= StIdle;
            timer_q    <= '0;
            err_q      <= 1'b1;
            err_code_q <= 2'b11;
         end else if (state_q != StIdle) begin
            timer_q <= timer_q + TmrW'(1);
         end
      end
   end

   assign data     = data_q;
   assign valid    = valid_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_swim_rx_decoder.sv
module tb_swim_rx_decoder;

   localparam int unsigned DB   = 8;
   localparam int unsigned MINL = 4;
   localparam int unsigned THR  = 66;
   localparam int unsigned TMO  = 2048;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          swim_in = 1'b1;
   logic [DB-1:0] data;
   logic          valid;
   logic          err;
   logic [1:0]    err_code;
   logic          busy;

   swim_rx_decoder #(
      .DATA_BITS   (DB),
      .MIN_LOW_CLKS(MINL),
      .THRESH_CLKS (THR),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .swim_in (swim_in),
      .data    (data),
      .valid   (valid),
      .err     (err),
      .err_code(err_code),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic [63:0] obs_q[$];
   logic [63:0] exp_q[$];

   // Reference model state: frame progress as a list of received bits.
   bit          in_frame = 1'b0;
   int          last_r = 0;
   bit          frame_bits[$];
   logic [7:0]  mdata = 8'h00;
   logic [1:0]  mcode = 2'b00;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Event word: cycle, kind (1 valid, 2 err, 3 both), err code, data.
   function automatic logic [63:0] ev(int c, int kind, logic [1:0] code, logic [7:0] d);
      return {32'(c), 8'(kind), 6'b0, code, 8'h00, d};
   endfunction

   always @(negedge clk) begin
      if (valid || err) begin
         obs_q.push_back(ev(cyc, int'({err, valid}), err ? err_code : 2'b00, data));
      end
   end

   function automatic void model_error(int t, logic [1:0] code);
      exp_q.push_back(ev(t, 2, code, mdata));
      mcode = code;
   endfunction

   // A frame that sees no accepted bit for more than TMO cycles after the last
   // one is aborted; the error shows 3 + TMO cycles after that bit's line rise.
   function automatic void model_flush(int now);
      if (in_frame && (last_r + 3 + int'(TMO) <= now)) begin
         model_error(last_r + 3 + int'(TMO), 2'b11);
         in_frame = 1'b0;
      end
   endfunction

   // Line released at cycle c after a low of width low_w; outcome visible at c+3.
   function automatic void model_rise(int c, int low_w);
      bit         b;
      logic [7:0] val;
      if (low_w < int'(MINL)) return;
      model_flush(c + 2);
      b = (low_w < int'(THR));
      if (!in_frame) begin
         if (b) begin
            in_frame = 1'b1;
            frame_bits.delete();
         end else begin
            model_error(c + 3, 2'b01);
         end
      end else begin
         frame_bits.push_back(b);
         if (frame_bits.size() == DB + 1) begin
            val = 8'h00;
            for (int i = 0; i < int'(DB); i++) val = {val[6:0], frame_bits[i]};
            mdata = val;
            if (frame_bits[DB] == (^val)) exp_q.push_back(ev(c + 3, 1, 2'b00, mdata));
            else model_error(c + 3, 2'b10);
            in_frame = 1'b0;
         end
      end
      last_r = c;
   endfunction

   task automatic pulse(input int low_w, input int high_w);
      int c;
      swim_in = 1'b0;
      repeat (low_w) @(posedge clk);
      #1;
      c = cyc;
      swim_in = 1'b1;
      model_rise(c, low_w);
      repeat (high_w) @(posedge clk);
      #1;
      model_flush(cyc);
      if (high_w >= 3) check("busy", 64'(busy), 64'(in_frame));
   endtask

   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
      model_flush(cyc);
      check("busy_idle", 64'(busy), 64'(in_frame));
   endtask

   task automatic send_bit(input bit b);
      pulse(b ? 12 : 120, 120);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit glitchy,
                             input bit fixed);
      logic [9:0] seq;
      int         lo;
      int         hi;
      seq = {1'b1, d, (^d) ^ bad_par};
      for (int i = 9; i >= 0; i--) begin
         if (fixed) lo = seq[i] ? 12 : 120;
         else lo = seq[i] ? int'($urandom_range(65, 4)) : int'($urandom_range(110, 66));
         hi = fixed ? 132 - lo : int'($urandom_range(60, 3));
         pulse(lo, hi);
         if (glitchy) pulse(fixed ? 2 : int'($urandom_range(3, 1)), 10);
      end
   endtask

   task automatic do_reset();
      model_flush(cyc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_frame = 1'b0;
      frame_bits.delete();
      mdata = 8'h00;
      mcode = 2'b00;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_data", 64'(data), 64'(0));
   endtask

   initial begin
      logic [7:0] bd;
      int         n;

      repeat (3) @(posedge clk);
      #1;
      check("reset_data", 64'(data), 64'(0));
      check("reset_valid", 64'(valid), 64'(0));
      check("reset_err", 64'(err), 64'(0));
      check("reset_code", 64'(err_code), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      gap(20);

      // Nominal frames: good and bad parity.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      gap(50);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      gap(50);

      // Lone long pulse while idle.
      pulse(120, 132);

      // Partial frame left to time out, then a clean frame.
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      gap(3000);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);

      // Glitches between every bit.
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      gap(30);

      // Width boundaries: 4 accepted, 3 ignored, 65 is a 1, 66 is a 0.
      pulse(4, 100);
      pulse(3, 100);
      pulse(65, 100);
      pulse(66, 100);
      bd = 8'hAC;
      for (int i = 5; i >= 0; i--) send_bit(bd[i]);
      send_bit(^bd);
      gap(30);

      // Reset mid-frame, then a full frame of ones.
      send_bit(1'b1);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      do_reset();
      gap(10);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      gap(20);

      // Randomized frames and stray pulses.
      for (int k = 0; k < 20; k++) begin
         send_frame(8'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0), 1'b0);
         if ($urandom_range(4, 0) == 0) pulse(int'($urandom_range(100, 66)), 40);
         gap(int'($urandom_range(40, 3)));
      end

      gap(int'(TMO) + 100);

      check("n_events", 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("event%0d", i), obs_q[i], exp_q[i]);
      check("data_final", 64'(data), 64'(mdata));
      check("err_code_hold", 64'(err_code), 64'(mcode));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/swim_rx_decoder.md
Name: swim_rx_decoder

Overview:
Receive-side companion to the team's timed-pulse generators on the SWIM link. The block samples the single-wire SWIM line and measures the width of each low pulse in clk cycles. It classifies each pulse as bit 1 (short low) or bit 0 (long low) and assembles target-to-host frames: start bit, DATA_BITS data bits, parity bit. It sits between the SWIM pad input and the UART bridge, delivering one byte per frame with a single-cycle strobe.

Parameters:
DATA_BITS, 8, data bits per frame, MSB first
MIN_LOW_CLKS, 4, low pulses shorter than this are glitches and ignored entirely
THRESH_CLKS, 66, low width < THRESH_CLKS decodes 1, >= THRESH_CLKS decodes 0 (48 MHz clk, 8 MHz SWIM: 1 = 12 clks low, 0 = 120 clks low)
TIMEOUT_CLKS, 2048, max clk cycles between accepted bits inside a frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
swim_in  input  1  asynchronous SWIM line level, idle high
data  output  DATA_BITS  last received frame payload
valid  output  1  one-cycle strobe: frame received, parity OK
err  output  1  one-cycle strobe: frame aborted or bad
err_code  output  2  01 start bit was 0, 10 parity mismatch, 11 timeout; holds until next err
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values: data=0, valid=0, err=0, err_code=00, busy=0; synchronizer flops=1; state=IDLE; all counters=0.
- Input: 2-FF synchronizer, then a registered copy for edge detection. Every measurement uses the synchronized signal.
- Low counter, 16 bits:
  - Cleared on the synchronized falling edge.
  - Increments every cycle the synchronized line is low.
  - Saturates at 0xFFFF.
- Rising edge with L = low count:
  - L < MIN_LOW_CLKS: glitch. No state, counter or timer change.
  - Otherwise decode bit = (L < THRESH_CLKS).
- FSM:
  - IDLE: bit 1 -> DATA, bit_idx=0. Bit 0 -> err=1, err_code=01, remain IDLE.
  - DATA: shift bit in, MSB first. After DATA_BITS bits -> PARITY.
  - PARITY: received bit == XOR of the shifted data -> data<=shift reg, valid=1. Otherwise data<=shift reg, err=1, err_code=10. Both cases -> IDLE.
- Frame timer:
  - Cleared on every accepted bit; runs in DATA and PARITY only.
  - Reaching TIMEOUT_CLKS -> err=1, err_code=11, IDLE, partial data discarded, data unchanged.
  - A timeout and a bit decode on the same cycle: the bit wins and the timer clears.
- Latency: valid/err rises exactly one clk after the cycle the synchronized rising edge is detected. That is 3 clk edges after the first clk edge sampling swim_in high.
- valid and err are mutually exclusive and are high for exactly one cycle.
- A new frame's start bit may follow immediately; no recovery gap is required.
- rst mid-frame: immediate return to IDLE, no valid/err pulse, partial bits dropped.
- Line held low indefinitely: the counter saturates. Inside a frame, the frame timer times out. The eventual rising edge decodes 0 in whatever state is then current.

Test Plan:
- Frame 0xA5: start(12 clk low, 120 high), bits 1,0,1,0,0,1,0,1 using 12/120-clk lows in 132-clk bit periods, parity 0 -> valid=1 one cycle, data=0xA5, err=0, busy low afterwards.
- Same frame with parity bit 1 -> err=1, err_code=10, data=0xA5, valid never asserted.
- Idle, then 120-clk low pulse -> err=1, err_code=01, busy stays 0.
- Start bit + 3 data bits, then line high for 3000 clks -> err=1, err_code=11 exactly 2048 clks after the 3rd bit's rising edge, data unchanged; a following clean 0x3C frame -> valid, data=0x3C.
- 2-clk low glitches inserted between every bit of 0x5A -> valid, data=0x5A.
- Low-pulse boundaries: 4-clk low start bit -> decoded 1, busy=1; 3-clk low -> ignored; 65-clk low data bit -> 1; 66-clk low -> 0.
- rst for 1 cycle after 5 data bits -> busy=0, no strobe; the next full 0xFF frame (parity 0) -> valid, data=0xFF.
